// File: rtl/matrix_scan_ctrl.sv
// Row scanner and double-buffered 8x16 frame store for the LED matrix.
// Game logic writes the back buffer; swaps happen only at frame boundaries.
module matrix_scan_ctrl #(
    parameter int DIV          = 1000,
    parameter int BLANK        = 50,
    parameter bit COPY_ON_SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_x,
    input  logic [2:0]  wr_y,
    input  logic        wr_data,
    input  logic        clr,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        swap_pending,
    output logic        frame_start,
    output logic [7:0]  MATRIX_ROW,
    output logic [15:0] MATRIX_COL
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0]  div_cnt_q, div_cnt_d;
    logic [2:0]   row_q, row_d;
    logic [127:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic         front_sel_q, front_sel_d;
    logic         swap_pending_q, swap_pending_d;
    logic         swap_ack_q, swap_ack_d;
    logic         frame_start_q, frame_start_d;
    logic [7:0]   mrow_q, mrow_d;
    logic [15:0]  mcol_q, mcol_d;

    logic [127:0] front, back_nxt;
    logic         dwell_end, frame_end, do_swap;

    always_comb begin
        front    = front_sel_q ? buf1_q : buf0_q;
        // clear first, then the write, so a same-cycle write survives the clear
        back_nxt = front_sel_q ? buf0_q : buf1_q;
        if (clr)   back_nxt = '0;
        if (wr_en) back_nxt[{wr_y, wr_x}] = wr_data;

        dwell_end = (div_cnt_q == DIV_LAST);
        frame_end = dwell_end && (row_q == 3'd7);
        do_swap   = frame_end && swap_pending_q;

        div_cnt_d      = dwell_end ? '0 : div_cnt_q + 16'd1;
        row_d          = dwell_end ? row_q + 3'd1 : row_q;
        swap_pending_d = do_swap ? 1'b0 : (swap_pending_q | swap_req);
        swap_ack_d     = do_swap;
        front_sel_d    = front_sel_q ^ do_swap;

        buf0_d = buf0_q;
        buf1_d = buf1_q;
        if (front_sel_q) buf0_d = back_nxt;
        else             buf1_d = back_nxt;
        // the outgoing back (with this edge's edits) becomes front and seeds the new back
        if (do_swap && COPY_ON_SWAP) begin
            buf0_d = back_nxt;
            buf1_d = back_nxt;
        end

        frame_start_d = (row_q == 3'd0) && (div_cnt_q == 16'd0);
        mrow_d        = ~(8'd1 << row_q);
        mcol_d        = (int'(div_cnt_q) < BLANK) ? 16'h0000 : front[{row_q, 4'd0} +: 16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q      <= '0;
            row_q          <= '0;
            buf0_q         <= '0;
            buf1_q         <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
            frame_start_q  <= 1'b0;
            mrow_q         <= 8'hFF;
            mcol_q         <= 16'h0000;
        end else begin
            div_cnt_q      <= div_cnt_d;
            row_q          <= row_d;
            buf0_q         <= buf0_d;
            buf1_q         <= buf1_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
            frame_start_q  <= frame_start_d;
            mrow_q         <= mrow_d;
            mcol_q         <= mcol_d;
        end
    end

    assign swap_ack     = swap_ack_q;
    assign swap_pending = swap_pending_q;
    assign frame_start  = frame_start_q;
    assign MATRIX_ROW   = mrow_q;
    assign MATRIX_COL   = mcol_q;

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Scan controller and double-buffered frame store for the 8x16 LED matrix.
- Game logic draws into a back buffer through a pixel write port. The block scans the front buffer row by row onto MATRIX_ROW/MATRIX_COL with a programmable dwell per row and anti-ghost blanking.
- Buffer swaps are requested with a handshake and take effect only at frame boundaries, so no partial frame is ever shown.

Parameters:
- DIV, 1000, clock cycles per row dwell (>= BLANK+1, <= 65535).
- BLANK, 50, cycles at the start of each row dwell during which MATRIX_COL is forced to 0 (>= 0).
- COPY_ON_SWAP, 1, 1: on swap, the new back buffer is loaded with a copy of the new front buffer; 0: plain ping-pong, the back buffer keeps the old front contents.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  pixel write strobe to the back buffer.
- wr_x  in  4  column 0..15.
- wr_y  in  3  row 0..7.
- wr_data  in  1  pixel value (1 = lit).
- clr  in  1  one-cycle pulse; clears the entire back buffer.
- swap_req  in  1  one-cycle pulse; requests a swap at the next frame end.
- swap_ack  out  1  one-cycle pulse on the edge where the swap occurs.
- swap_pending  out  1  high from the request until the swap occurs.
- frame_start  out  1  one-cycle pulse when the row 0 dwell begins.
- MATRIX_ROW  out  8  active-low row select.
- MATRIX_COL  out  16  active-high column data.

Behaviour:
- Reset (async, rst_n=0):
  - div_cnt=0, row=0, both buffers all-zero, front select=0.
  - swap_pending=0, swap_ack=0, frame_start=0, MATRIX_ROW=8'hFF, MATRIX_COL=16'h0000.
- Counters:
  - div_cnt counts 0..DIV-1 and wraps.
  - On wrap, row increments 0..7 and wraps 7 -> 0. Row order is 0,1,..7.
- Outputs: all registered, reflecting the current counter state with 1 cycle latency.
  - MATRIX_ROW = ~(1<<row) for the whole dwell; never two rows low.
  - MATRIX_COL = 0 while div_cnt < BLANK, otherwise front[row*16+15 : row*16], with MATRIX_COL[c] = pixel (c,row).
  - BLANK=0 means no blanking.
- frame_start: asserted in the output cycle corresponding to row=0, div_cnt=0, including the first scan after reset.
- Frame end: the edge where row=7 and div_cnt=DIV-1.
- Write port:
  - wr_en writes back[wr_y*16+wr_x] = wr_data on that edge.
  - Any number of writes per frame; the front buffer is never writable.
- Clear: clr zeroes the back buffer. If wr_en is asserted in the same cycle, the clear applies first and the write then lands (write wins for that pixel).
- Swap handshake:
  - swap_req sets swap_pending.
  - At frame end with swap_pending=1, the front select toggles, swap_pending clears, and swap_ack pulses for one cycle.
  - The next frame (starting at row 0) shows the new front.
  - swap_req while already pending is absorbed: only one swap occurs.
  - swap_req arriving on the frame-end edge itself: not taken this frame, taken next frame end.
- COPY_ON_SWAP=1:
  - On the swap edge, the new back buffer is loaded with the full contents of the new front.
  - A write or clear on that same edge is applied to the outgoing back buffer before the copy, so it is included in both buffers.
  - Writes on later cycles affect the back buffer only.
- COPY_ON_SWAP=0: a write on the swap edge lands in the outgoing back buffer (the new front) and appears on screen.
- Reset mid-frame: immediately returns to the reset state. Pending swaps and buffer contents are lost; the scan restarts at row 0.
- No combinational paths from inputs to outputs.

Test Plan (DIV=8, BLANK=2 unless stated):
- Reset, idle 64 cycles.
  - MATRIX_ROW sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 8 cycles.
  - MATRIX_COL always 0.
  - frame_start every 64 cycles, first pulse right after reset.
- Write (x=3,y=2,1) and (x=15,y=7,1), swap_req, wait one frame.
  - From the frame after swap_ack: row FB shows COL=0x0008 on dwell cycles 2..7 and 0 on cycles 0..1.
  - Row 7F shows COL=0x8000.
  - No change is visible before swap_ack.
- swap_req mid-frame at row 3.
  - swap_pending high until the row 7 / div_cnt=7 edge, then swap_ack pulses once.
  - A second swap_req while pending yields no extra ack.
- COPY_ON_SWAP=1: after the first swap, write (0,0,1) then swap again.
  - Display shows both the earlier pixels and (0,0).
- COPY_ON_SWAP=0: same sequence.
  - Second frame shows only (0,0) plus whatever was in the old front.
- clr and wr_en(x=5,y=1,1) in the same cycle on a full back buffer, then swap.
  - Row FD shows 0x0020; all other rows 0.
- Assert rst_n=0 during row 5 with a swap pending.
  - Outputs go to FF/0000 asynchronously.
  - After release, no swap_ack occurs and the scan restarts at FE.
